// File: rtl/pe_sequencer.sv
// Host-side sequencer for one MAC PE: buffers a job, drives the PE through reset/load/start/stream, returns the result.
// Build option PE_SEQ_FILTER_REUSE_EN keeps the filter buffer across jobs (LOAD_F only after reset).
module pe_sequencer #(
   parameter int FILTER_WIDTH = 8,
   parameter int INPUT_WIDTH  = 8,
   parameter int PE_OUT_WIDTH = 24,
   parameter int NUM_DATA     = 16,
   parameter int ACC_TIMEOUT  = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flt_valid,
   output logic                             flt_ready,
   input  logic [FILTER_WIDTH-1:0]          flt_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [INPUT_WIDTH-1:0]           in_data,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [PE_OUT_WIDTH-1:0]          res_data,
   output logic                             res_timeout,
   output logic                             pe_rst,
   output logic                             pe_aload,
   output logic                             pe_start,
   output logic [FILTER_WIDTH*NUM_DATA-1:0] pe_a,
   output logic [INPUT_WIDTH-1:0]           pe_b,
   input  logic [PE_OUT_WIDTH-1:0]          pe_y,
   input  logic                             pe_acc_valid,
   output logic                             busy
);
   // state    | meaning
   // LOAD_F   | accept NUM_DATA filter words
   // LOAD_I   | accept NUM_DATA input samples
   // CLEAR    | pe_rst pulse
   // ALOAD    | pe_aload pulse, PE latches pe_a
   // START    | pe_start pulse with sample 0
   // STREAM   | samples 1..NUM_DATA-1, one per cycle
   // WAIT_ACC | wait for pe_acc_valid or timeout
   // RESULT   | hold result until accepted

   localparam int IW = $clog2(NUM_DATA);
   localparam int CW = IW + 1;
   localparam int TW = $clog2(ACC_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_DATA - 1);

   typedef enum logic [2:0] {
      LOAD_F, LOAD_I, CLEAR, ALOAD, START, STREAM, WAIT_ACC, RESULT
   } state_t;

   state_t state, state_nxt;
   logic [CW-1:0] fcnt, icnt, kcnt;
   logic [TW-1:0] tcnt;
   logic [FILTER_WIDTH-1:0] fbuf [NUM_DATA];
   logic [INPUT_WIDTH-1:0]  ibuf [NUM_DATA];

   for (genvar g = 0; g < NUM_DATA; g++) begin : g_pe_a
      assign pe_a[g*FILTER_WIDTH +: FILTER_WIDTH] = fbuf[g];
   end

   always_comb begin
      state_nxt = state;
      flt_ready = 1'b0;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      pe_rst    = 1'b0;
      pe_aload  = 1'b0;
      pe_start  = 1'b0;
      pe_b      = '0;
      busy      = !((state == LOAD_F && fcnt == '0) || (state == LOAD_I && icnt == '0));
      case (state)
         LOAD_F: begin
            flt_ready = 1'b1;
            if (flt_valid && fcnt == LAST) state_nxt = LOAD_I;
         end
         LOAD_I: begin
            in_ready = 1'b1;
            if (in_valid && icnt == LAST) state_nxt = CLEAR;
         end
         CLEAR: begin
            pe_rst    = 1'b1;
            state_nxt = ALOAD;
         end
         ALOAD: begin
            pe_aload  = 1'b1;
            state_nxt = START;
         end
         START: begin
            pe_start  = 1'b1;
            pe_b      = ibuf[0];
            state_nxt = STREAM;
         end
         STREAM: begin
            pe_b = ibuf[kcnt[IW-1:0]];
            if (kcnt == LAST) state_nxt = WAIT_ACC;
         end
         WAIT_ACC: begin
            if (pe_acc_valid || tcnt == '0) state_nxt = RESULT;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
`ifdef PE_SEQ_FILTER_REUSE_EN
               state_nxt = LOAD_I;
`else
               state_nxt = LOAD_F;
`endif
            end
         end
         default: state_nxt = LOAD_F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD_F;
         fcnt        <= '0;
         icnt        <= '0;
         kcnt        <= '0;
         tcnt        <= TW'(ACC_TIMEOUT);
         res_data    <= '0;
         res_timeout <= 1'b0;
         for (int i = 0; i < NUM_DATA; i++) fbuf[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == LOAD_F && flt_valid) begin
            fbuf[fcnt[IW-1:0]] <= flt_data;
            fcnt <= (fcnt == LAST) ? '0 : fcnt + 1'b1;
         end
         if (state == LOAD_I && in_valid)
            icnt <= (icnt == LAST) ? '0 : icnt + 1'b1;
         if (state == START)
            kcnt <= CW'(1);
         else if (state == STREAM)
            kcnt <= kcnt + 1'b1;
         // timeout down-counter armed during STREAM, terminal count 0 ends WAIT_ACC
         if (state == STREAM)
            tcnt <= TW'(ACC_TIMEOUT);
         else if (state == WAIT_ACC && tcnt != '0)
            tcnt <= tcnt - 1'b1;
         if (state == WAIT_ACC) begin
            if (pe_acc_valid) begin
               res_data    <= pe_y;
               res_timeout <= 1'b0;
            end else if (tcnt == '0) begin
               res_data    <= pe_y;
               res_timeout <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && state == LOAD_I && in_valid)
         ibuf[icnt[IW-1:0]] <= in_data;
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural MAC PE and a result scoreboard.
module tb_pe_sequencer;
   localparam int FW = 8, IWD = 8, OW = 24, N = 16, TO = 64;

   logic clk = 1'b0, reset;
   logic flt_valid, flt_ready, in_valid, in_ready, res_valid, res_ready;
   logic [FW-1:0] flt_data;
   logic [IWD-1:0] in_data, pe_b;
   logic [OW-1:0] res_data, pe_y;
   logic res_timeout, pe_rst, pe_aload, pe_start, pe_acc_valid, busy;
   logic [FW*N-1:0] pe_a;

   pe_sequencer #(.FILTER_WIDTH(FW), .INPUT_WIDTH(IWD), .PE_OUT_WIDTH(OW),
                  .NUM_DATA(N), .ACC_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_timeout(res_timeout), .pe_rst(pe_rst), .pe_aload(pe_aload),
      .pe_start(pe_start), .pe_a(pe_a), .pe_b(pe_b), .pe_y(pe_y),
      .pe_acc_valid(pe_acc_valid), .busy(busy));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, job_t0 = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural PE: acc_valid NUM_DATA+2 cycles after pe_start falls
   logic [FW-1:0] m_a [N];
   logic [OW-1:0] m_acc = '0;
   int m_idx = 0, m_wait = 0;
   bit m_run = 0, acc_en = 1;
   logic m_valid = 1'b0;
   assign pe_y = m_acc;
   assign pe_acc_valid = m_valid;

   always @(posedge clk) begin
      if (pe_rst) begin
         m_acc <= '0; m_idx <= 0; m_run <= 0; m_wait <= 0; m_valid <= 1'b0;
         for (int i = 0; i < N; i++) m_a[i] <= '0;
      end else begin
         if (pe_aload) for (int i = 0; i < N; i++) m_a[i] <= pe_a[i*FW +: FW];
         if (pe_start) begin
            m_acc <= OW'(m_a[0]) * OW'(pe_b);
            m_idx <= 1; m_run <= 1; m_wait <= 0;
         end else if (m_run) begin
            if (m_idx < N) begin
               m_acc <= m_acc + OW'(m_a[m_idx]) * OW'(pe_b);
               m_idx <= m_idx + 1;
            end
            m_wait <= m_wait + 1;
            if (m_wait == N + 1 && acc_en) m_valid <= 1'b1;
         end
      end
   end

   typedef struct { logic [OW-1:0] data; logic to; } exp_t;
   exp_t q[$];
   logic [FW-1:0]  tf [N];
   logic [IWD-1:0] ti [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_flt(input bit bubble);
      for (int i = 0; i < N; i++) begin
         int n = 0;
         if (bubble) begin
            flt_valid = 1'b0; flt_data = FW'($urandom); @(negedge clk);
         end
         flt_valid = 1'b1; flt_data = tf[i];
         while (!flt_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) chk("flt_ready_wait", 0, 1);
         @(negedge clk);
      end
      flt_valid = 1'b0;
   endtask

   task automatic send_in(input bit bubble);
      for (int i = 0; i < N; i++) begin
         int n = 0;
         if (bubble) begin
            in_valid = 1'b0; in_data = IWD'($urandom); @(negedge clk);
         end
         in_valid = 1'b1; in_data = ti[i];
         while (!in_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) chk("in_ready_wait", 0, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic run_job(input bit do_flt, input bit bubble, input bit exp_to, input int abort_k);
      exp_t e;
      logic [OW-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s += OW'(tf[i]) * OW'(ti[i]);
      if (do_flt) send_flt(bubble);
      send_in(bubble);
      e.data = s; e.to = exp_to;
      q.push_back(e);
      job_t0 = cyc;
      chk("pulse_+1_rst", {29'd0, pe_rst, pe_aload, pe_start}, 32'b100);
      @(negedge clk);
      chk("pulse_+2_aload", {29'd0, pe_rst, pe_aload, pe_start}, 32'b010);
      @(negedge clk);
      chk("pulse_+3_start", {29'd0, pe_rst, pe_aload, pe_start}, 32'b001);
      chk("pe_b_tap0", pe_b, ti[0]);
      for (int k = 1; k < N; k++) begin
         @(negedge clk);
         chk("pe_b_stream", pe_b, ti[k]);
         if (k == abort_k) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("abort_res_valid", res_valid, 0);
            chk("abort_pe_b", pe_b, 0);
            chk("abort_flt_ready", flt_ready, 1);
            void'(q.pop_back());
            return;
         end
      end
      @(negedge clk);
      chk("wait_acc_pe_b", pe_b, 0);
   endtask

   task automatic collect(input int stall);
      int n = 0, acc_cyc = -1;
      bit ok = 1;
      exp_t e;
      logic [OW-1:0] d0;
      while (!res_valid && n < 200) begin
         if (pe_acc_valid && acc_cyc < 0) acc_cyc = cyc;
         @(negedge clk); n++;
      end
      if (n >= 200 || q.size() == 0) begin
         chk("res_valid_wait", 0, 1);
         return;
      end
      e = q.pop_front();
      if (e.to) chk("timeout_latency", cyc - job_t0 + 1, N + TO + 4);
      else      chk("res_after_acc", cyc, acc_cyc + 1);
      d0 = res_data;
      for (int i = 0; i < stall; i++) begin
         ok &= res_valid && res_data == d0 && !flt_ready && !in_ready && busy;
         @(negedge clk);
      end
      if (stall > 0) chk("backpressure_hold", ok, 1);
      chk("res_data", res_data, e.data);
      chk("res_timeout", res_timeout, e.to);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
`ifdef PE_SEQ_FILTER_REUSE_EN
      chk("next_in_ready", in_ready, 1);
      chk("next_flt_ready", flt_ready, 0);
`else
      chk("next_flt_ready", flt_ready, 1);
`endif
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flt_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      flt_data = '0; in_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_flt_ready", flt_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res", {7'd0, res_timeout, res_data}, 0);
      chk("rst_pulses", {29'd0, pe_rst, pe_aload, pe_start}, 0);
      chk("rst_pe_a_zero", pe_a == '0, 1);
      chk("rst_pe_b", pe_b, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < N; i++) begin tf[i] = 1; ti[i] = IWD'(i + 1); end
      run_job(1, 0, 0, -1);
      collect(0);

`ifdef PE_SEQ_FILTER_REUSE_EN
      for (int i = 0; i < N; i++) ti[i] = 2;
      chk("reuse_flt_ready", flt_ready, 0);
      run_job(0, 0, 0, -1);
      collect(0);
`else
      for (int i = 0; i < N; i++) begin tf[i] = 2; ti[i] = 3; end
      run_job(1, 1, 0, -1);
      collect(0);

      for (int i = 0; i < N; i++) begin tf[i] = FW'($urandom); ti[i] = IWD'($urandom); end
      run_job(1, 0, 0, -1);
      collect(20);

      acc_en = 0;
      for (int i = 0; i < N; i++) begin tf[i] = FW'(i); ti[i] = 5; end
      run_job(1, 0, 1, -1);
      collect(0);
      acc_en = 1;

      for (int i = 0; i < N; i++) begin tf[i] = 9; ti[i] = 9; end
      run_job(1, 0, 0, 7);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin tf[i] = FW'($urandom); ti[i] = IWD'($urandom); end
      run_job(1, 1, 0, -1);
      collect(3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
